// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// mem_port_arbiter_if
// Shared 32-bit memory port between the arbiter (master) and external memory (slave).
//   req_valid/req_ready : request handshake, fields held while req_valid && !req_ready
//   req_addr            : word-aligned byte address
//   req_we/req_wstrb    : store flag and byte enables (wstrb 0 for reads)
//   req_wdata           : lane-replicated store data
//   rsp_valid/rsp_rdata : one pulse per request, read data (ignored for stores)
interface mem_port_arbiter_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_we;
   logic [3:0]  req_wstrb;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   modport master (
      output req_valid, req_addr, req_we, req_wstrb, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_we, req_wstrb, req_wdata,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one memory port between instruction fetch (i_*) and load/store (d_*).
// One transaction in flight: IDLE -> REQ -> WAIT -> RESP -> IDLE, or IDLE -> RESP
// for a data request with an illegal access type (or a misaligned one when checked).
// Data wins simultaneous requests unless fetch has been passed over
// FETCH_STARVE_LIMIT times in a row.
//   clk, rst_n            : clock, async active-low reset
//   i_req_* / i_rsp_*     : fetch request handshake and one-cycle response
//   d_req_* / d_rsp_*     : data request (access type, addr, wdata) and response
//   mem                   : memory port (mem_port_arbiter_if.master)
// Optional build macro: MEM_PORT_ARBITER_ALIGN_CHECK_EN -- reject misaligned
// LH/LHU/SH/LW/SW with d_rsp_err instead of silently ignoring low address bits.
module mem_port_arbiter #(
   parameter int unsigned FETCH_STARVE_LIMIT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_req_valid,
   output logic               i_req_ready,
   input  logic [31:0]        i_req_addr,
   output logic               i_rsp_valid,
   output logic [31:0]        i_rsp_data,
   input  logic               d_req_valid,
   output logic               d_req_ready,
   input  logic [31:0]        d_req_addr,
   input  logic [3:0]         d_req_access_type,
   input  logic [31:0]        d_req_wdata,
   output logic               d_rsp_valid,
   output logic [31:0]        d_rsp_rdata,
   output logic               d_rsp_err,
   mem_port_arbiter_if.master mem
);

   localparam logic [3:0] AT_NONE = 4'd0, AT_LB = 4'd1, AT_LH = 4'd2, AT_LW = 4'd3,
                          AT_LBU = 4'd4, AT_LHU = 4'd5, AT_SB = 4'd6, AT_SH = 4'd7,
                          AT_SW = 4'd8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt;
   logic              starve, grant_d, grant_i, d_err, d_misalign;
   logic              owner_d, err_q;
   logic [3:0]        type_q;
   logic [31:0]       addr_q, wdata_q, rdata_q;
   logic [3:0][7:0]   rd_lanes;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       ld_data;

   assign starve  = (cnt == 4'(FETCH_STARVE_LIMIT));
   assign grant_d = d_req_valid & d_req_ready;
   assign grant_i = i_req_valid & i_req_ready;

   always_comb begin
      d_misalign = 1'b0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHECK_EN
      case (d_req_access_type)
         AT_LH, AT_LHU, AT_SH: d_misalign = d_req_addr[0];
         AT_LW, AT_SW:         d_misalign = |d_req_addr[1:0];
         default:              d_misalign = 1'b0;
      endcase
`endif
   end

   assign d_err = (d_req_access_type == AT_NONE) | (d_req_access_type > AT_SW) | d_misalign;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (grant_d && d_err)       state_nxt = RESP;
            else if (grant_d || grant_i) state_nxt = REQ;
         end
         REQ:  if (mem.req_ready) state_nxt = WAIT;
         WAIT: if (mem.rsp_valid) state_nxt = RESP;
         RESP: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs; readies may look at the other requester's valid
   always_comb begin
      i_req_ready   = 1'b0;
      d_req_ready   = 1'b0;
      mem.req_valid = 1'b0;
      i_rsp_valid   = 1'b0;
      d_rsp_valid   = 1'b0;
      d_rsp_err     = 1'b0;
      case (state)
         IDLE: begin
            d_req_ready = !(starve && i_req_valid);
            i_req_ready = !d_req_valid || starve;
         end
         REQ:  mem.req_valid = 1'b1;
         RESP: begin
            i_rsp_valid = !owner_d;
            d_rsp_valid = owner_d;
            d_rsp_err   = owner_d & err_q;
         end
         default: ;
      endcase
   end

   // transaction capture; fetch grants load type NONE so no store steering applies
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_d <= 1'b0;
         err_q   <= 1'b0;
         type_q  <= AT_NONE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (grant_d) begin
            owner_d <= 1'b1;
            err_q   <= d_err;
            type_q  <= d_req_access_type;
            addr_q  <= d_req_addr;
            wdata_q <= d_req_wdata;
            rdata_q <= '0;
         end else if (grant_i) begin
            owner_d <= 1'b0;
            err_q   <= 1'b0;
            type_q  <= AT_NONE;
            addr_q  <= i_req_addr;
            wdata_q <= '0;
            rdata_q <= '0;
         end else if (state == WAIT && mem.rsp_valid) begin
            rdata_q <= mem.rsp_rdata;
         end
      end
   end

   // starvation counter: only data grants that pass over a waiting fetch count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          cnt <= '0;
      else if (grant_i)    cnt <= '0;
      else if (grant_d)    cnt <= !i_req_valid ? 4'd0 : (starve ? cnt : 4'(cnt + 4'd1));
   end

   // store steering
   always_comb begin
      mem.req_we    = 1'b0;
      mem.req_wstrb = 4'b0000;
      mem.req_wdata = '0;
      case (type_q)
         AT_SB: begin
            mem.req_we    = 1'b1;
            mem.req_wstrb = 4'b0001 << addr_q[1:0];
            mem.req_wdata = {4{wdata_q[7:0]}};
         end
         AT_SH: begin
            mem.req_we    = 1'b1;
            mem.req_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
            mem.req_wdata = {2{wdata_q[15:0]}};
         end
         AT_SW: begin
            mem.req_we    = 1'b1;
            mem.req_wstrb = 4'b1111;
            mem.req_wdata = wdata_q;
         end
         default: ;
      endcase
   end

   assign mem.req_addr = {addr_q[31:2], 2'b00};

   // load extraction
   assign rd_lanes = rdata_q;
   assign ld_byte  = rd_lanes[addr_q[1:0]];
   assign ld_half  = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

   always_comb begin
      ld_data = '0;
      case (type_q)
         AT_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         AT_LBU: ld_data = {24'd0, ld_byte};
         AT_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
         AT_LHU: ld_data = {16'd0, ld_half};
         AT_LW:  ld_data = rdata_q;
         default: ld_data = '0;
      endcase
   end

   assign d_rsp_rdata = (d_rsp_valid && !err_q) ? ld_data : 32'd0;
   assign i_rsp_data  = i_rsp_valid ? rdata_q : 32'd0;

endmodule
